dmem_port_arb: RTL and testbench
================================

# dmem_port_arb

Two-requester arbiter and sequencer for the byte-column data memory macro (`dmem_ext`) in the OpenPiton WARP-V integration. Shares the single memory port between the core load/store unit (`core_*`) and an external requester (`ext_*`), such as the L1.5/debug fill path. It drives the memory's store-valid, speculative-load, column-enable, address and write-data inputs, and returns the registered read data to whichever requester issued the load. Arbitration is fixed-priority to the core, with a starvation bound for the external port; a round-robin variant is available as a compile option.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word address width; matches the memory.
- `COL_WIDTH`, 8: bits per byte column.
- `NB_COL`, 4: columns per word; data width is `DW` = `NB_COL*COL_WIDTH`.
- `MAX_WAIT`, 4: cycles the external port may be denied before it is forced to win (legal range 1..15).

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `core_req_valid` in 1: core request present.
- `core_req_ready` out 1: core request accepted this cycle.
- `core_req_wr` in 1: 1 = store, 0 = load.
- `core_req_addr` in ADDR_WIDTH: word address.
- `core_req_we` in NB_COL: column enables; stores only.
- `core_req_wdata` in DW: store data.
- `core_rsp_valid` out 1: response for a previously accepted core request.
- `core_rsp_rdata` out DW: load data; 0 for store responses.
- `ext_req_valid`, `ext_req_ready`, `ext_req_wr`, `ext_req_addr`, `ext_req_we`, `ext_req_wdata`, `ext_rsp_valid`, `ext_rsp_rdata`: same as the `core_*` equivalents, for the external requester.
- `mem_valid_st` out 1: to memory `valid_st`.
- `mem_spec_ld` out 1: to memory `spec_ld`.
- `mem_we` out NB_COL: to memory `we`.
- `mem_addr` out ADDR_WIDTH: to memory `addr`.
- `mem_din` out DW: to memory `din`.
- `mem_dout` in DW: from memory `dout`; valid the cycle after `mem_spec_ld`.

## Operation
- Accepting a request:
  - A request is accepted when `X_req_valid && X_req_ready` in the same cycle.
  - At most one requester is accepted per cycle.
  - `ready` is combinational from `valid` and the arbitration state. It is never asserted without the matching `valid`.
- Default arbitration: the core wins.
- Starvation bound:
  - `wait_cnt` (4 bits) increments each cycle in which `ext_req_valid=1` and the external port is not accepted.
  - It clears on external acceptance, and holds when `ext_req_valid=0`.
  - When `wait_cnt == MAX_WAIT`, the external port wins over the core.
- Memory drive, combinational from the winning request:
  - Accepted store: `mem_valid_st=1`, `mem_we=req_we`, `mem_spec_ld=0`.
  - Accepted load: `mem_spec_ld=1`, `mem_valid_st=0`, `mem_we=0`.
  - `mem_addr` and `mem_din` take the winner's fields.
  - With no acceptance, all `mem_*` outputs are 0.
- Response tracking: a registered tag `{rsp_pend, rsp_owner, rsp_is_ld}` is captured on every acceptance.
- Response generation, in the cycle after acceptance:
  - `X_rsp_valid=1` for the owner only.
  - `X_rsp_rdata` is `mem_dout` for loads and 0 for stores.
  - The non-owner's `rsp_rdata` is 0.
- Back-to-back: a new request may be accepted in the same cycle a response is delivered, so sustained throughput is 1 request per cycle.
- Store then load to the same address on consecutive cycles: the load returns the new data. Per-column writes commit at the edge and the load reads on the next edge.
- Store with `we=0`: accepted, produces no memory write, and still returns a response.

## Timing
- Request-to-response latency is exactly 1 cycle for both loads and stores. There is no backpressure on responses.
- Reset values:
  - All `*_rsp_valid` = 0 and all `*_rsp_rdata` = 0.
  - `wait_cnt` = 0, `rsp_pend` = 0.
  - The round-robin pointer points to the core.
  - `ready` and `mem_*` are 0 while `reset=1`.
- Reset asserted with a load in flight: the response is dropped, so `rsp_valid` stays 0 in the following cycle.
- Simultaneous `core_req_valid` and `ext_req_valid` with `wait_cnt < MAX_WAIT`: the core is accepted and `wait_cnt` increments.
- `wait_cnt` saturates at `MAX_WAIT`. It cannot exceed `MAX_WAIT` because the external port is then guaranteed the grant.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin arbitration replaces fixed priority and `wait_cnt`.
  - A 1-bit `last` register records the most recently accepted requester and resets to core.
  - On contention, the requester that is not `last` wins.
  - `MAX_WAIT` is ignored.
- `DMEM_ARB_RR_EN` undefined: fixed core priority with the `MAX_WAIT` starvation bound, as in Operation.

## Test plan
- Core store then load:
  - Stimulus: core store addr 0x005, `we=4'b0101`, `wdata=0xAABBCCDD` onto a word of 0; next cycle core load 0x005.
  - Required: `core_rsp_valid` in cycles 1 and 2; load `rdata=0x00BB00DD`; `ext_rsp_valid` stays 0.
- External-only load:
  - Stimulus: ext load 0x3FF after a prior ext store of 0x12345678 with `we=4'hF`.
  - Required: `ext_rsp_rdata=0x12345678` exactly 1 cycle after acceptance.
- Starvation (fixed priority, `MAX_WAIT=4`):
  - Stimulus: both `valid` held high continuously.
  - Required: acceptance pattern core ×4, ext ×1, repeating; the ext grant occurs when `wait_cnt==4`.
- Round-robin (`DMEM_ARB_RR_EN`):
  - Stimulus: both `valid` held high continuously.
  - Required: strict alternation core, ext, core, ext, starting with ext after reset (`last` = core).
- Reset mid-operation:
  - Stimulus: core load accepted in cycle N, `reset=1` in cycle N+1.
  - Required: `core_rsp_valid=0` in N+1; all outputs 0; first post-reset contention grants core.
- Back-to-back mixed traffic:
  - Stimulus: 16 alternating core/ext random loads and stores, one per cycle.
  - Required: every accepted request yields exactly one response to its owner 1 cycle later; read data matches the scoreboard model.

Source files
------------

// File: rtl/dmem_port_arb.sv
// +----------------------------------------------------------------------------+
// | dmem_port_arb: two-requester arbiter/sequencer for the dmem_ext port.      |
// | Option macro: DMEM_ARB_RR_EN (round-robin instead of core priority).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_port_arb #(
  parameter int ADDR_WIDTH = 10,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 4,
  parameter int MAX_WAIT   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          core_req_valid,
  output logic                          core_req_ready,
  input  logic                          core_req_wr,
  input  logic [ADDR_WIDTH-1:0]         core_req_addr,
  input  logic [NB_COL-1:0]             core_req_we,
  input  logic [NB_COL*COL_WIDTH-1:0]   core_req_wdata,
  output logic                          core_rsp_valid,
  output logic [NB_COL*COL_WIDTH-1:0]   core_rsp_rdata,
  input  logic                          ext_req_valid,
  output logic                          ext_req_ready,
  input  logic                          ext_req_wr,
  input  logic [ADDR_WIDTH-1:0]         ext_req_addr,
  input  logic [NB_COL-1:0]             ext_req_we,
  input  logic [NB_COL*COL_WIDTH-1:0]   ext_req_wdata,
  output logic                          ext_rsp_valid,
  output logic [NB_COL*COL_WIDTH-1:0]   ext_rsp_rdata,
  output logic                          mem_valid_st,
  output logic                          mem_spec_ld,
  output logic [NB_COL-1:0]             mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [NB_COL*COL_WIDTH-1:0]   mem_din,
  input  logic [NB_COL*COL_WIDTH-1:0]   mem_dout
);

  localparam int DW = NB_COL * COL_WIDTH;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_EXT  = 1'b1
  } owner_e;

  logic   core_grant;
  logic   ext_grant;
  logic   rsp_pend_q, rsp_pend_d;
  owner_e rsp_owner_q, rsp_owner_d;
  logic   rsp_is_ld_q, rsp_is_ld_d;

`ifdef DMEM_ARB_RR_EN
  owner_e last_q, last_d;

  // On contention the requester that did not win most recently takes the port.
  always_comb begin
    core_grant = 1'b0;
    ext_grant  = 1'b0;
    last_d     = last_q;
    if (!reset) begin
      if (core_req_valid && ext_req_valid) begin
        if (last_q == OWNER_CORE) ext_grant = 1'b1;
        else                      core_grant = 1'b1;
      end else begin
        core_grant = core_req_valid;
        ext_grant  = ext_req_valid;
      end
      if (core_grant)     last_d = OWNER_CORE;
      else if (ext_grant) last_d = OWNER_EXT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= OWNER_CORE;
    else       last_q <= last_d;
  end
`else
  localparam logic [3:0] MAX_WAIT_W = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       ext_force;

  assign ext_force = (wait_cnt_q == MAX_WAIT_W);

  // Core has priority unless the external port has waited MAX_WAIT cycles.
  always_comb begin
    core_grant = 1'b0;
    ext_grant  = 1'b0;
    wait_cnt_d = wait_cnt_q;
    if (!reset) begin
      ext_grant  = ext_req_valid && (!core_req_valid || ext_force);
      core_grant = core_req_valid && !ext_grant;
      if (ext_grant)
        wait_cnt_d = 4'd0;
      else if (ext_req_valid && !ext_force)
        wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt_q <= 4'd0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign core_req_ready = core_grant;
  assign ext_req_ready  = ext_grant;

  always_comb begin
    mem_valid_st = 1'b0;
    mem_spec_ld  = 1'b0;
    mem_we       = '0;
    mem_addr     = '0;
    mem_din      = '0;
    rsp_pend_d   = core_grant || ext_grant;
    rsp_owner_d  = ext_grant ? OWNER_EXT : OWNER_CORE;
    rsp_is_ld_d  = 1'b0;
    if (core_grant) begin
      mem_valid_st = core_req_wr;
      mem_spec_ld  = !core_req_wr;
      mem_we       = core_req_wr ? core_req_we : '0;
      mem_addr     = core_req_addr;
      mem_din      = core_req_wdata;
      rsp_is_ld_d  = !core_req_wr;
    end else if (ext_grant) begin
      mem_valid_st = ext_req_wr;
      mem_spec_ld  = !ext_req_wr;
      mem_we       = ext_req_wr ? ext_req_we : '0;
      mem_addr     = ext_req_addr;
      mem_din      = ext_req_wdata;
      rsp_is_ld_d  = !ext_req_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= OWNER_CORE;
      rsp_is_ld_q <= 1'b0;
    end else begin
      rsp_pend_q  <= rsp_pend_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_is_ld_q <= rsp_is_ld_d;
    end
  end

  // Responses are gated by reset so an in-flight load is dropped immediately.
  logic          rsp_live;
  logic [DW-1:0] rsp_data;

  assign rsp_live       = rsp_pend_q && !reset;
  assign rsp_data       = rsp_is_ld_q ? mem_dout : '0;
  assign core_rsp_valid = rsp_live && (rsp_owner_q == OWNER_CORE);
  assign ext_rsp_valid  = rsp_live && (rsp_owner_q == OWNER_EXT);
  assign core_rsp_rdata = core_rsp_valid ? rsp_data : '0;
  assign ext_rsp_rdata  = ext_rsp_valid  ? rsp_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arb.sv
// Self-checking bench for dmem_port_arb: memory macro model plus a
// cycle-level reference of the arbitration and response rules.
`default_nettype none

module tb_dmem_port_arb;

  localparam int AW = 10;
  localparam int CW = 8;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int MW = 4;

  typedef struct packed {
    logic          v;
    logic          wr;
    logic [AW-1:0] addr;
    logic [NC-1:0] we;
    logic [DW-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          core_req_valid, core_req_ready, core_req_wr, core_rsp_valid;
  logic [AW-1:0] core_req_addr;
  logic [NC-1:0] core_req_we;
  logic [DW-1:0] core_req_wdata, core_rsp_rdata;
  logic          ext_req_valid, ext_req_ready, ext_req_wr, ext_rsp_valid;
  logic [AW-1:0] ext_req_addr;
  logic [NC-1:0] ext_req_we;
  logic [DW-1:0] ext_req_wdata, ext_rsp_rdata;
  logic          mem_valid_st, mem_spec_ld;
  logic [NC-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  dmem_port_arb #(
    .ADDR_WIDTH(AW), .COL_WIDTH(CW), .NB_COL(NC), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_wr(core_req_wr), .core_req_addr(core_req_addr),
    .core_req_we(core_req_we), .core_req_wdata(core_req_wdata),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
    .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
    .ext_req_wr(ext_req_wr), .ext_req_addr(ext_req_addr),
    .ext_req_we(ext_req_we), .ext_req_wdata(ext_req_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_rdata(ext_rsp_rdata),
    .mem_valid_st(mem_valid_st), .mem_spec_ld(mem_spec_ld),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Byte-column memory macro: writes commit at the edge, loads register dout.
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  logic          mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<AW); i++) mem_arr[i] <= '0;
      mem_dout <= '0;
    end else begin
      if (mem_valid_st)
        for (int b = 0; b < NC; b++)
          if (mem_we[b]) mem_arr[mem_addr][b*CW +: CW] <= mem_din[b*CW +: CW];
      if (mem_spec_ld) mem_dout <= mem_arr[mem_addr];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            waits;
  bit            last_ext;
  bit            m_pend, m_owner_ext;
  logic [DW-1:0] m_data;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.v     = 1'b1;
    r.wr    = 1'($urandom_range(0, 1));
    r.addr  = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
    r.we    = 4'($urandom);
    r.wdata = $urandom;
    return r;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic rst, input req_t c, input req_t e);
    bit   gc, ge;
    req_t w;
    @(negedge clk);
    reset          = rst;
    core_req_valid = c.v;  core_req_wr = c.wr;  core_req_addr = c.addr;
    core_req_we    = c.we; core_req_wdata = c.wdata;
    ext_req_valid  = e.v;  ext_req_wr = e.wr;   ext_req_addr = e.addr;
    ext_req_we     = e.we; ext_req_wdata = e.wdata;
    #1;
    chk("core_rsp_valid", 64'(core_rsp_valid), 64'(!rst && m_pend && !m_owner_ext));
    chk("ext_rsp_valid",  64'(ext_rsp_valid),  64'(!rst && m_pend && m_owner_ext));
    chk("core_rsp_rdata", 64'(core_rsp_rdata), 64'((!rst && m_pend && !m_owner_ext) ? m_data : '0));
    chk("ext_rsp_rdata",  64'(ext_rsp_rdata),  64'((!rst && m_pend && m_owner_ext) ? m_data : '0));

    gc = 1'b0;
    ge = 1'b0;
    if (!rst) begin
      if (c.v && e.v) begin
`ifdef DMEM_ARB_RR_EN
        ge = !last_ext;
`else
        ge = (waits == MW);
`endif
        gc = !ge;
      end else begin
        gc = c.v;
        ge = e.v;
      end
    end
    w = gc ? c : (ge ? e : '0);
    chk("core_req_ready", 64'(core_req_ready), 64'(gc));
    chk("ext_req_ready",  64'(ext_req_ready),  64'(ge));
    chk("mem_valid_st",   64'(mem_valid_st),   64'(w.v && w.wr));
    chk("mem_spec_ld",    64'(mem_spec_ld),    64'(w.v && !w.wr));
    chk("mem_we",         64'(mem_we),         64'((w.v && w.wr) ? w.we : '0));
    chk("mem_addr",       64'(mem_addr),       64'(w.addr));
    chk("mem_din",        64'(mem_din),        64'(w.wdata));

    if (rst) begin
      m_pend   = 1'b0;
      waits    = 0;
      last_ext = 1'b0;
    end else begin
      m_pend      = gc || ge;
      m_owner_ext = ge;
      m_data      = '0;
      if (m_pend) begin
        if (w.wr) begin
          for (int b = 0; b < NC; b++)
            if (w.we[b]) ref_mem[w.addr][b*CW +: CW] = w.wdata[b*CW +: CW];
        end else begin
          m_data = ref_mem[w.addr];
        end
        last_ext = ge;
      end
      if (ge)                       waits = 0;
      else if (e.v && waits < MW)   waits++;
    end
  endtask

  req_t idle, cr, er;

  initial begin
    idle = '0;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
    waits = 0; last_ext = 1'b0; m_pend = 1'b0; m_owner_ext = 1'b0; m_data = '0;
    mem_clr = 1'b1;
    reset = 1'b1;
    core_req_valid = 0; core_req_wr = 0; core_req_addr = '0; core_req_we = '0; core_req_wdata = '0;
    ext_req_valid  = 0; ext_req_wr  = 0; ext_req_addr  = '0; ext_req_we  = '0; ext_req_wdata  = '0;

    // Reset with live requests present: everything must stay quiet.
    cr = rnd_req(); er = rnd_req();
    step(1'b1, cr, er);
    step(1'b1, idle, idle);
    mem_clr = 1'b0;

    // Core store then load to the same word
    cr = '{v:1'b1, wr:1'b1, addr:10'h005, we:4'b0101, wdata:32'hAABBCCDD};
    step(1'b0, cr, idle);
    cr = '{v:1'b1, wr:1'b0, addr:10'h005, we:4'b0000, wdata:32'h0};
    step(1'b0, cr, idle);
    step(1'b0, idle, idle);
    chk("st_ld_rdata", 64'(core_rsp_rdata), 64'h00BB00DD);
    chk("st_ld_extq",  64'(ext_rsp_valid),  64'h0);

    // External store then load at the top address
    er = '{v:1'b1, wr:1'b1, addr:10'h3FF, we:4'hF, wdata:32'h12345678};
    step(1'b0, idle, er);
    er = '{v:1'b1, wr:1'b0, addr:10'h3FF, we:4'h0, wdata:32'h0};
    step(1'b0, idle, er);
    step(1'b0, idle, idle);
    chk("ext_ld_rdata", 64'(ext_rsp_rdata), 64'h12345678);

    // Continuous contention from a clean reset
    step(1'b1, idle, idle);
    for (int i = 0; i < 12; i++) begin
      cr = rnd_req(); er = rnd_req();
      step(1'b0, cr, er);
`ifdef DMEM_ARB_RR_EN
      chk("rr_pattern", 64'(ext_req_ready), 64'((i % 2) == 0));
`else
      chk("starve_pattern", 64'(ext_req_ready), 64'((i % 5) == 4));
`endif
    end

    // Reset with a core load in flight
    step(1'b1, idle, idle);
    cr = '{v:1'b1, wr:1'b0, addr:10'h005, we:4'h0, wdata:32'h0};
    step(1'b0, cr, idle);
    step(1'b1, idle, idle);
    chk("rst_drop_rsp", 64'(core_rsp_valid), 64'h0);
    step(1'b0, idle, idle);
    cr = rnd_req(); er = rnd_req();
    step(1'b0, cr, er);
`ifdef DMEM_ARB_RR_EN
    chk("post_rst_grant", 64'(ext_req_ready), 64'h1);
`else
    chk("post_rst_grant", 64'(core_req_ready), 64'h1);
`endif

    // Back-to-back alternating single-requester traffic
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) step(1'b0, rnd_req(), idle);
      else            step(1'b0, idle, rnd_req());
    end

    // Random contention with sporadic valids
    for (int i = 0; i < 400; i++) begin
      cr = rnd_req(); er = rnd_req();
      cr.v = ($urandom_range(0, 3) != 0);
      er.v = ($urandom_range(0, 2) != 0);
      step(1'b0, cr, er);
    end
    step(1'b0, idle, idle);
    step(1'b0, idle, idle);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
